// File: rtl/tile_req.sv
// tile_req: per-tile candidate search against a shared row bias bus.
// Walks a one-hot pool index upward, requests the bus value for each index,
// commits the first value that is nonzero and not claimed by a peer tile, and
// supports backtracking to resume the walk past the committed index.
// Optional feature macro: TILE_REQ_TRIES_EN adds the 'tries' evaluation counter.

`ifndef GRID_LEN
`define GRID_LEN 9
`endif

module tile_req #(
  parameter int unsigned w = `GRID_LEN
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   backtrack,
  input  logic [w-1:0]           occupied,
  output logic                   update,
  output logic [w-1:0]           rqindex,
  input  logic [w-1:0]           busvalue,
  output logic [w-1:0]           value,
  output logic                   done,
  output logic                   fail
`ifdef TILE_REQ_TRIES_EN
  ,
  output logic [$clog2(w+1)-1:0] tries
`endif
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StReq   = 2'd1;
  localparam logic [1:0] StCheck = 2'd2;
  localparam logic [1:0] StHold  = 2'd3;

  logic [1:0]   state_q, state_d;
  logic [w-1:0] rqindex_q, rqindex_d;
  logic [w-1:0] value_q, value_d;
  logic         accept;
  logic         last;

  // Candidate is usable only if the bus returned something and no peer owns it.
  assign accept = (busvalue != '0) && ((busvalue & occupied) == '0);
  assign last   = rqindex_q[w-1];

  // Next-state, pool index and committed value; strobes decoded from the state.
  always_comb begin
    state_d   = state_q;
    rqindex_d = rqindex_q;
    value_d   = value_q;
    update    = 1'b0;
    done      = 1'b0;
    fail      = 1'b0;
    case (state_q)
      StIdle: begin
        // start has priority; backtrack is meaningless here
        if (start) begin
          rqindex_d = w'(1);
          value_d   = '0;
          state_d   = StReq;
        end
      end
      StReq: begin
        update  = 1'b1;
        state_d = StCheck;
      end
      StCheck: begin
        if (accept) begin
          value_d = busvalue;
          done    = 1'b1;
          state_d = StHold;
        end else if (last) begin
          rqindex_d = '0;
          value_d   = '0;
          fail      = 1'b1;
          state_d   = StIdle;
        end else begin
          rqindex_d = rqindex_q << 1;
          state_d   = StReq;
        end
      end
      StHold: begin
        // occupied is deliberately not looked at: a commit is never revoked
        if (backtrack) begin
          value_d = '0;
          if (last) begin
            rqindex_d = '0;
            fail      = 1'b1;
            state_d   = StIdle;
          end else begin
            rqindex_d = rqindex_q << 1;
            state_d   = StReq;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= StIdle;
      rqindex_q <= '0;
      value_q   <= '0;
    end else begin
      state_q   <= state_d;
      rqindex_q <= rqindex_d;
      value_q   <= value_d;
    end
  end

  assign rqindex = rqindex_q;
  assign value   = value_q;

`ifdef TILE_REQ_TRIES_EN
  localparam int unsigned TW = $clog2(w + 1);

  logic [TW-1:0] tries_q, tries_d;

  // Count CHECK evaluations since the last start, saturating at w.
  always_comb begin
    tries_d = tries_q;
    if (state_q == StIdle && start) begin
      tries_d = '0;
    end else if (state_q == StCheck && tries_q < TW'(w)) begin
      tries_d = tries_q + TW'(1);
    end
  end

  // Evaluation counter register.
  always_ff @(posedge clock) begin
    if (!reset) begin
      tries_q <= '0;
    end else begin
      tries_q <= tries_d;
    end
  end

  assign tries = tries_q;
`endif

endmodule

// File: tb/tb_tile_req.sv
// tb_tile_req: randomized self-checking bench for tile_req (w=9).
// The row bias bus returns the requested index one cycle after update, except
// for indices masked by 'hole', which read back as zero.

module tb_tile_req;

  localparam int unsigned W = 9;

  logic         clock = 1'b0;
  logic         reset;
  logic         start;
  logic         backtrack;
  logic [W-1:0] occupied;
  logic         update;
  logic [W-1:0] rqindex;
  logic [W-1:0] busvalue;
  logic [W-1:0] value;
  logic         done;
  logic         fail;
  logic [W-1:0] hole;
`ifdef TILE_REQ_TRIES_EN
  logic [$clog2(W+1)-1:0] tries;
  int tries_m;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  tile_req #(.w(W)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .backtrack(backtrack),
    .occupied (occupied),
    .update   (update),
    .rqindex  (rqindex),
    .busvalue (busvalue),
    .value    (value),
    .done     (done),
    .fail     (fail)
`ifdef TILE_REQ_TRIES_EN
    ,
    .tries    (tries)
`endif
  );

  always #5 clock = ~clock;

  // Row bias bus: identity pool, registered one cycle after the request.
  always @(posedge clock) busvalue <= update ? (rqindex & ~hole) : '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    start = 1'b0;
    backtrack = 1'b0;
    step();
    reset = 1'b1;
`ifdef TILE_REQ_TRIES_EN
    tries_m = 0;
`endif
  endtask

  // Caller has raised start or backtrack in the current cycle (cycle 0).
  // Reference: first index >= s not occupied and not a bus hole wins; each
  // candidate costs two cycles.
  task automatic search(input string tag, input int s, input logic [W-1:0] occ,
                        output int a);
    int n, cyc, reqs;
    a = -1;
    for (int i = s; i < W; i++) begin
      if (!occ[i] && !hole[i]) begin
        a = i;
        break;
      end
    end
    n = (a < 0) ? W - s : a - s + 1;
    occupied = occ;
    step();
    start = 1'b0;
    backtrack = 1'b0;
    cyc  = 1;
    reqs = 0;
    while (cyc <= 2 * W + 2) begin
      if (update) begin
        chk({tag, "/rqindex"}, 32'(rqindex), 32'(1) << (s + reqs));
        reqs++;
      end
      chk({tag, "/onehot0"}, 32'($onehot0(rqindex)), 32'(1));
      chk({tag, "/done&fail"}, 32'(done & fail), 32'(0));
      if (done || fail) break;
      step();
      cyc++;
    end
    chk({tag, "/done"}, 32'(done), 32'(a >= 0));
    chk({tag, "/fail"}, 32'(fail), 32'(a < 0));
    chk({tag, "/cycle"}, 32'(cyc), 32'(2 * n));
    chk({tag, "/requests"}, 32'(reqs), 32'(n));
    step();
    chk({tag, "/value"}, 32'(value), (a >= 0) ? (32'(1) << a) : 32'(0));
    chk({tag, "/update_after"}, 32'(update), 32'(0));
    chk({tag, "/pulse_after"}, 32'(done | fail), 32'(0));
    if (a < 0) chk({tag, "/rqindex_idle"}, 32'(rqindex), 32'(0));
`ifdef TILE_REQ_TRIES_EN
    tries_m = (tries_m + n > W) ? W : tries_m + n;
    chk({tag, "/tries"}, 32'(tries), 32'(tries_m));
`endif
  endtask

  task automatic do_start(input string tag, input logic [W-1:0] occ, output int a);
    start = 1'b1;
`ifdef TILE_REQ_TRIES_EN
    tries_m = 0;
`endif
    search(tag, 0, occ, a);
  endtask

  // Backtrack from HOLD while committed at index held.
  task automatic do_back(input string tag, input int held, input logic [W-1:0] occ,
                         output int a);
    backtrack = 1'b1;
    #1;
    if (held == W - 1) begin
      chk({tag, "/top_fail"}, 32'(fail), 32'(1));
      chk({tag, "/top_done"}, 32'(done), 32'(0));
      chk({tag, "/top_update"}, 32'(update), 32'(0));
      step();
      backtrack = 1'b0;
      chk({tag, "/top_value"}, 32'(value), 32'(0));
      chk({tag, "/top_update1"}, 32'(update), 32'(0));
      chk({tag, "/top_fail1"}, 32'(fail), 32'(0));
      a = -1;
    end else begin
      chk({tag, "/bt_pulse0"}, 32'(done | fail), 32'(0));
      search(tag, held + 1, occ, a);
    end
  endtask

  // In HOLD: output stability under changing occupied and an ignored start.
  task automatic hold_check(input string tag, input int a);
    logic [W-1:0] rq_keep;
    rq_keep = rqindex;
    for (int k = 0; k < 3; k++) begin
      occupied = W'($urandom);
      start = (k == 1);
      step();
      chk({tag, "/hold_value"}, 32'(value), 32'(1) << a);
      chk({tag, "/hold_rq"}, 32'(rqindex), 32'(rq_keep));
      chk({tag, "/hold_update"}, 32'(update | done | fail), 32'(0));
    end
    start = 1'b0;
  endtask

  initial begin
    int a;
    int b;
    reset = 1'b0;
    start = 1'b0;
    backtrack = 1'b0;
    occupied = '0;
    hole = '0;
`ifdef TILE_REQ_TRIES_EN
    tries_m = 0;
`endif
    step();
    step();
    chk("reset/value", 32'(value), 32'(0));
    chk("reset/rqindex", 32'(rqindex), 32'(0));
    chk("reset/strobes", 32'({update, done, fail}), 32'(0));
`ifdef TILE_REQ_TRIES_EN
    chk("reset/tries", 32'(tries), 32'(0));
`endif
    reset = 1'b1;
    step();

    // First free index committed immediately.
    do_start("free", 9'h000, a);
    hold_check("free", a);
    do_reset();

    // Four occupied indices skipped; commit at 0x010.
    do_start("occ0f", 9'h00F, a);
    // Backtrack with the next index now occupied; commit at 0x040.
    do_back("bt030", a, 9'h030, b);
    do_reset();

    // Commit at the top index, then backtrack fails immediately.
    do_start("top", 9'h0FF, a);
    do_back("top", a, 9'h000, b);

    // Fully occupied: fail after all nine candidates.
    do_start("full", 9'h1FF, a);
    step();
    chk("full/idle_update", 32'(update), 32'(0));

    // Backtrack ignored in IDLE.
    backtrack = 1'b1;
    step();
    step();
    backtrack = 1'b0;
    chk("idle_bt/update", 32'(update), 32'(0));
    chk("idle_bt/rqindex", 32'(rqindex), 32'(0));

    // start and backtrack together in IDLE: start wins.
    backtrack = 1'b1;
    do_start("both", 9'h000, a);
    do_reset();

    // Reset in the middle of a CHECK.
    start = 1'b1;
    occupied = '0;
    step();
    start = 1'b0;
    step();
    reset = 1'b0;
    step();
    chk("midreset/value", 32'(value), 32'(0));
    chk("midreset/rqindex", 32'(rqindex), 32'(0));
    chk("midreset/strobes", 32'({update, done, fail}), 32'(0));
`ifdef TILE_REQ_TRIES_EN
    chk("midreset/tries", 32'(tries), 32'(0));
    tries_m = 0;
`endif
    reset = 1'b1;
    step();

    // A zero bus value is rejected even when the index is free.
    hole = 9'h003;
    do_start("hole", 9'h000, a);
    do_reset();
    hole = '0;

    // Randomized search/backtrack chains.
    for (int it = 0; it < 20; it++) begin
      hole = ($urandom_range(0, 3) == 0) ? W'($urandom) & W'($urandom) : '0;
      do_start("rand", W'($urandom) & W'($urandom), a);
      while (a >= 0) begin
        if ($urandom_range(0, 1) == 1) hold_check("rand", a);
        do_back("rand_bt", a, W'($urandom) & W'($urandom), b);
        a = b;
      end
      step();
      chk("rand/idle_update", 32'(update), 32'(0));
    end
    hole = '0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
